mem_bus_ctrl: RTL and testbench

Parametrised memory-bus controller between the datapath's load/store request port and N-region on-chip memory (RAM + ROM). Decodes byte addresses against configurable base/size windows and inserts per-region wait states. Handles byte/half/word/dword lanes with sign/zero extension. Reports unmapped, misaligned and ROM-write faults. Stalls the datapath through a ready handshake instead of a shared tri-state data bus.

---
 rtl/mem_bus_pkg.sv | 34 +++
 rtl/mem_bus_ctrl_lane_align.sv | 45 ++++
 rtl/mem_bus_ctrl.sv | 180 ++++++++++++++++++
 tb/tb_mem_bus_ctrl.sv | 251 +++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_bus_pkg.sv
// Shared definitions for the memory-bus controller slice.
// Holds the request size encodings, the controller state and region
// enums, and the helper that turns a size code into a byte-lane mask.
package mem_bus_pkg;

    localparam logic [1:0] SZ_B = 2'b00;
    localparam logic [1:0] SZ_H = 2'b01;
    localparam logic [1:0] SZ_W = 2'b10;
    localparam logic [1:0] SZ_D = 2'b11;

    typedef enum logic [1:0] {
        S_IDLE,
        S_ACCESS,
        S_RESP,
        S_FAULT
    } state_t;

    typedef enum logic [1:0] {
        REG_NONE,
        REG_RAM,
        REG_ROM
    } region_t;

    // Right-justified byte-lane mask for an access of the given size.
    function automatic logic [7:0] size_mask(input logic [1:0] size);
        case (size)
            SZ_B:    return 8'h01;
            SZ_H:    return 8'h03;
            SZ_W:    return 8'h0F;
            default: return 8'hFF;
        endcase
    endfunction

endpackage

// File: rtl/mem_bus_ctrl_lane_align.sv
// mem_lane_align: combinational byte-lane steering for a 64-bit bus.
// Stores: byte enables and store data moved up to the addressed lane.
// Loads:  device data moved down from the addressed lane, trimmed to the
//         access size and sign- or zero-extended.
// Ports:
//   size, offset, is_signed : latched request attributes (offset = addr[2:0])
//   wdata                   : right-justified store data
//   dev_rdata               : raw dword from the selected device
//   be, lane_wdata          : store-side lane enables and aligned data
//   load_data               : extended load result
module mem_lane_align
    import mem_bus_pkg::*;
#(
    parameter int DATA_WIDTH = 64
) (
    input  logic [1:0]            size,
    input  logic [2:0]            offset,
    input  logic                  is_signed,
    input  logic [DATA_WIDTH-1:0] wdata,
    input  logic [DATA_WIDTH-1:0] dev_rdata,
    output logic [7:0]            be,
    output logic [DATA_WIDTH-1:0] lane_wdata,
    output logic [DATA_WIDTH-1:0] load_data
);

    logic [5:0]            bit_shift;
    logic [DATA_WIDTH-1:0] shifted;

    assign bit_shift  = {offset, 3'b000};
    assign be         = size_mask(size) << offset;
    assign lane_wdata = wdata << bit_shift;
    assign shifted    = dev_rdata >> bit_shift;

    // The sign bit sits at the top of the trimmed field, so it moves with size.
    always_comb begin
        load_data = shifted;
        case (size)
            SZ_B:    load_data = {{(DATA_WIDTH-8){is_signed & shifted[7]}}, shifted[7:0]};
            SZ_H:    load_data = {{(DATA_WIDTH-16){is_signed & shifted[15]}}, shifted[15:0]};
            SZ_W:    load_data = {{(DATA_WIDTH-32){is_signed & shifted[31]}}, shifted[31:0]};
            default: load_data = shifted;
        endcase
    end

endmodule

// File: rtl/mem_bus_ctrl.sv
// mem_bus_ctrl: load/store port to on-chip RAM + ROM.
// Decodes the byte address against the RAM and ROM windows, runs a fixed
// number of wait cycles per region, and returns a one-cycle ready pulse
// (with error for faults) instead of driving a shared bus.
// Ports:
//   clock, reset                   : clock and async active-high reset
//   req_*                          : datapath request / response handshake
//   ram_en/we/addr/be/wdata/rdata  : RAM device port (rdata one cycle after en)
//   rom_en/addr/rdata              : ROM device port (rdata one cycle after en)
module mem_bus_ctrl
    import mem_bus_pkg::*;
#(
    parameter int                    DATA_WIDTH    = 64,
    parameter int                    ADDR_WIDTH    = 32,
    parameter logic [ADDR_WIDTH-1:0] RAM_BASE      = 32'h00020000,
    parameter int                    RAM_ADDR_BITS = 10,
    parameter logic [ADDR_WIDTH-1:0] ROM_BASE      = 32'h00000000,
    parameter int                    ROM_ADDR_BITS = 10,
    parameter int                    RAM_WAIT      = 0,
    parameter int                    ROM_WAIT      = 1
) (
    input  logic                     clock,
    input  logic                     reset,
    input  logic                     req_read,
    input  logic                     req_write,
    input  logic [ADDR_WIDTH-1:0]    req_addr,
    input  logic [1:0]               req_size,
    input  logic                     req_signed,
    input  logic [DATA_WIDTH-1:0]    req_wdata,
    output logic [DATA_WIDTH-1:0]    req_rdata,
    output logic                     req_ready,
    output logic                     req_error,
    output logic                     ram_en,
    output logic                     ram_we,
    output logic [RAM_ADDR_BITS-4:0] ram_addr,
    output logic [7:0]               ram_be,
    output logic [DATA_WIDTH-1:0]    ram_wdata,
    input  logic [DATA_WIDTH-1:0]    ram_rdata,
    output logic                     rom_en,
    output logic [ROM_ADDR_BITS-4:0] rom_addr,
    input  logic [DATA_WIDTH-1:0]    rom_rdata
);

    localparam int LO_BITS = (RAM_ADDR_BITS > ROM_ADDR_BITS) ? RAM_ADDR_BITS : ROM_ADDR_BITS;
    localparam logic [ADDR_WIDTH-1:0] RAM_LOW = ADDR_WIDTH'((64'd1 << RAM_ADDR_BITS) - 64'd1);
    localparam logic [ADDR_WIDTH-1:0] ROM_LOW = ADDR_WIDTH'((64'd1 << ROM_ADDR_BITS) - 64'd1);

    state_t                state, next_state;
    region_t               region_q, dec_region;
    logic                  dec_fault, misaligned;
    logic [LO_BITS-1:0]    addr_q;
    logic [1:0]            size_q;
    logic                  signed_q;
    logic                  write_q;
    logic [DATA_WIDTH-1:0] wdata_q;
    logic [2:0]            wait_cnt;
    logic [7:0]            lane_be;
    logic [DATA_WIDTH-1:0] lane_wdata;
    logic [DATA_WIDTH-1:0] load_data;
    logic [DATA_WIDTH-1:0] dev_rdata;

    // Address decode on the live request; RAM is checked first so an
    // overlapping window resolves to RAM.
    always_comb begin
        dec_region = REG_NONE;
        if ((req_addr & ~RAM_LOW) == RAM_BASE) begin
            dec_region = REG_RAM;
        end else if ((req_addr & ~ROM_LOW) == ROM_BASE) begin
            dec_region = REG_ROM;
        end
        case (req_size)
            SZ_H:    misaligned = req_addr[0];
            SZ_W:    misaligned = |req_addr[1:0];
            SZ_D:    misaligned = |req_addr[2:0];
            default: misaligned = 1'b0;
        endcase
        dec_fault = (req_read & req_write) | (dec_region == REG_NONE) | misaligned
                    | ((dec_region == REG_ROM) & req_write);
    end

    // State register plus the request latch and wait counter, all cleared
    // by reset so every derived output returns to zero at once.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state    <= S_IDLE;
            region_q <= REG_NONE;
            addr_q   <= '0;
            size_q   <= '0;
            signed_q <= 1'b0;
            write_q  <= 1'b0;
            wdata_q  <= '0;
            wait_cnt <= '0;
        end else begin
            state <= next_state;
            if (state == S_IDLE && (req_read || req_write)) begin
                region_q <= dec_region;
                addr_q   <= req_addr[LO_BITS-1:0];
                size_q   <= req_size;
                signed_q <= req_signed;
                write_q  <= req_write;
                wdata_q  <= req_wdata;
                wait_cnt <= (dec_region == REG_RAM) ? 3'(RAM_WAIT) : 3'(ROM_WAIT);
            end else if (state == S_ACCESS && wait_cnt != 3'd0) begin
                wait_cnt <= wait_cnt - 3'd1;
            end
        end
    end

    // Next-state logic: ACCESS holds until the wait counter has run out.
    always_comb begin
        next_state = state;
        case (state)
            S_IDLE: begin
                if (req_read || req_write) begin
                    next_state = dec_fault ? S_FAULT : S_ACCESS;
                end
            end
            S_ACCESS: begin
                if (wait_cnt == 3'd0) begin
                    next_state = S_RESP;
                end
            end
            default: next_state = S_IDLE;
        endcase
    end

    assign dev_rdata = (region_q == REG_ROM) ? rom_rdata : ram_rdata;

    mem_lane_align #(
        .DATA_WIDTH(DATA_WIDTH)
    ) u_lane_align (
        .size      (size_q),
        .offset    (addr_q[2:0]),
        .is_signed (signed_q),
        .wdata     (wdata_q),
        .dev_rdata (dev_rdata),
        .be        (lane_be),
        .lane_wdata(lane_wdata),
        .load_data (load_data)
    );

    // Outputs are purely a function of state and latched request, so a
    // reset (which forces IDLE) silences every output immediately.
    always_comb begin
        req_rdata = '0;
        req_ready = 1'b0;
        req_error = 1'b0;
        ram_en    = 1'b0;
        ram_we    = 1'b0;
        ram_addr  = '0;
        ram_be    = '0;
        ram_wdata = '0;
        rom_en    = 1'b0;
        rom_addr  = '0;
        case (state)
            S_ACCESS: begin
                if (region_q == REG_RAM) begin
                    ram_en    = 1'b1;
                    ram_we    = write_q;
                    ram_addr  = addr_q[RAM_ADDR_BITS-1:3];
                    ram_be    = lane_be;
                    ram_wdata = write_q ? lane_wdata : '0;
                end else begin
                    rom_en   = 1'b1;
                    rom_addr = addr_q[ROM_ADDR_BITS-1:3];
                end
            end
            S_RESP: begin
                req_ready = 1'b1;
                req_rdata = write_q ? '0 : load_data;
            end
            S_FAULT: begin
                req_ready = 1'b1;
                req_error = 1'b1;
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_mem_bus_ctrl.sv
// Directed self-checking bench for mem_bus_ctrl with default parameters
// (RAM at 0x20000 no wait, ROM at 0x0 one wait) and simple RAM/ROM models.
module tb_mem_bus_ctrl;
    import mem_bus_pkg::*;

    logic        clock;
    logic        reset;
    logic        req_read, req_write, req_signed;
    logic [31:0] req_addr;
    logic [1:0]  req_size;
    logic [63:0] req_wdata, req_rdata;
    logic        req_ready, req_error;
    logic        ram_en, ram_we, rom_en;
    logic [6:0]  ram_addr, rom_addr;
    logic [7:0]  ram_be;
    logic [63:0] ram_wdata, ram_rdata, rom_rdata;

    logic [63:0] ram_mem [0:127];
    logic [63:0] rom_mem [0:127];

    int total;
    int bad;

    int          cap_ready_cyc, cap_en_cycles, cap_first_en;
    logic [7:0]  cap_be;
    logic [63:0] cap_wdata, cap_rdata;
    logic        cap_we, cap_err, cap_bubble_ready;
    logic [6:0]  cap_ram_addr, cap_rom_addr;
    logic        b2b_ready [1:5];
    logic [63:0] b2b_rdata [1:5];

    mem_bus_ctrl dut (
        .clock     (clock),
        .reset     (reset),
        .req_read  (req_read),
        .req_write (req_write),
        .req_addr  (req_addr),
        .req_size  (req_size),
        .req_signed(req_signed),
        .req_wdata (req_wdata),
        .req_rdata (req_rdata),
        .req_ready (req_ready),
        .req_error (req_error),
        .ram_en    (ram_en),
        .ram_we    (ram_we),
        .ram_addr  (ram_addr),
        .ram_be    (ram_be),
        .ram_wdata (ram_wdata),
        .ram_rdata (ram_rdata),
        .rom_en    (rom_en),
        .rom_addr  (rom_addr),
        .rom_rdata (rom_rdata)
    );

    // 100 MHz-style free-running clock.
    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Synchronous RAM/ROM models: read data appears the cycle after enable;
    // contents are re-seeded while reset is high.
    always @(posedge clock) begin
        if (reset) begin
            for (int i = 0; i < 128; i++) begin
                ram_mem[i] <= 64'd0;
                rom_mem[i] <= 64'd0;
            end
            ram_mem[0] <= 64'h0123_4567_80AB_CDEF;
            ram_mem[2] <= 64'hCAFE_F00D_0BAD_BEEF;
            rom_mem[0] <= 64'hDEAD_BEEF_1234_5678;
            rom_mem[1] <= 64'h0F1E_2D3C_4B5A_6978;
            ram_rdata  <= 64'd0;
            rom_rdata  <= 64'd0;
        end else begin
            if (ram_en) begin
                if (ram_we) begin
                    for (int i = 0; i < 8; i++) begin
                        if (ram_be[i]) ram_mem[ram_addr][8*i +: 8] <= ram_wdata[8*i +: 8];
                    end
                end
                ram_rdata <= ram_mem[ram_addr];
            end
            if (rom_en) rom_rdata <= rom_mem[rom_addr];
        end
    end

    // Single comparison point: counts every check and reports mismatches.
    task automatic checkOutput(input string tag, input logic [63:0] actual, input logic [63:0] expected);
        total++;
        if (actual !== expected) begin
            bad++;
            $display("[TB] FAIL %s: got=%h expected=%h", tag, actual, expected);
        end
    endtask

    task automatic stepCycle();
        @(posedge clock);
        #1;
    endtask

    task automatic applyStimulus(input logic rd, input logic wr, input logic [31:0] addr,
                                 input logic [1:0] size, input logic sgn, input logic [63:0] wdata);
        req_read   = rd;
        req_write  = wr;
        req_addr   = addr;
        req_size   = size;
        req_signed = sgn;
        req_wdata  = wdata;
    endtask

    // Present one request in cycle 0, drop it in cycle 1, and record what the
    // device ports and response did until ready (bounded to 20 cycles).
    task automatic runAccess(input logic rd, input logic wr, input logic [31:0] addr,
                             input logic [1:0] size, input logic sgn, input logic [63:0] wdata);
        applyStimulus(rd, wr, addr, size, sgn, wdata);
        cap_ready_cyc = -1;
        cap_en_cycles = 0;
        cap_first_en  = -1;
        cap_be = '0; cap_wdata = '0; cap_we = 1'b0; cap_ram_addr = '0; cap_rom_addr = '0;
        cap_err = 1'b0; cap_rdata = '0;
        for (int c = 1; c <= 20; c++) begin
            stepCycle();
            if (c == 1) applyStimulus(1'b0, 1'b0, 32'd0, SZ_B, 1'b0, 64'd0);
            if (ram_en || rom_en) begin
                cap_en_cycles++;
                if (cap_first_en < 0) begin
                    cap_first_en = c;
                    cap_be       = ram_be;
                    cap_wdata    = ram_wdata;
                    cap_we       = ram_we;
                    cap_ram_addr = ram_addr;
                    cap_rom_addr = rom_addr;
                end
            end
            if (req_ready) begin
                cap_ready_cyc = c;
                cap_err       = req_error;
                cap_rdata     = req_rdata;
                break;
            end
        end
        stepCycle();
        cap_bubble_ready = req_ready;
    endtask

    initial begin
        total = 0;
        bad   = 0;
        reset = 1'b1;
        applyStimulus(1'b0, 1'b0, 32'd0, SZ_B, 1'b0, 64'd0);
        repeat (3) stepCycle();

        checkOutput("rst_ready", {63'd0, req_ready}, 64'd0);
        checkOutput("rst_error", {63'd0, req_error}, 64'd0);
        checkOutput("rst_rdata", req_rdata, 64'd0);
        checkOutput("rst_ports", {ram_en, ram_we, rom_en, ram_be, ram_addr, rom_addr}, 64'd0);
        reset = 1'b0;
        stepCycle();

        // RAM dword store at dword index 1.
        runAccess(1'b0, 1'b1, 32'h0002_0008, SZ_D, 1'b0, 64'h1122_3344_5566_7788);
        checkOutput("wr_en_cycles", 64'(cap_en_cycles), 64'd1);
        checkOutput("wr_first_en", 64'(cap_first_en), 64'd1);
        checkOutput("wr_we", {63'd0, cap_we}, 64'd1);
        checkOutput("wr_be", {56'd0, cap_be}, 64'hFF);
        checkOutput("wr_ram_addr", {57'd0, cap_ram_addr}, 64'd1);
        checkOutput("wr_wdata", cap_wdata, 64'h1122_3344_5566_7788);
        checkOutput("wr_ready_cyc", 64'(cap_ready_cyc), 64'd2);
        checkOutput("wr_error", {63'd0, cap_err}, 64'd0);
        checkOutput("wr_bubble", {63'd0, cap_bubble_ready}, 64'd0);
        checkOutput("wr_mem", ram_mem[1], 64'h1122_3344_5566_7788);

        // Byte load of lane 3 (0x80), signed then unsigned.
        runAccess(1'b1, 1'b0, 32'h0002_0003, SZ_B, 1'b1, 64'd0);
        checkOutput("sb_ready_cyc", 64'(cap_ready_cyc), 64'd2);
        checkOutput("sb_rdata", cap_rdata, 64'hFFFF_FFFF_FFFF_FF80);
        checkOutput("sb_be", {56'd0, cap_be}, 64'h08);
        runAccess(1'b1, 1'b0, 32'h0002_0003, SZ_B, 1'b0, 64'd0);
        checkOutput("ub_rdata", cap_rdata, 64'h80);

        // Upper-word store at dword 4, then signed word readback.
        runAccess(1'b0, 1'b1, 32'h0002_0024, SZ_W, 1'b0, 64'h0000_0000_AABB_CCDD);
        checkOutput("sw_be", {56'd0, cap_be}, 64'hF0);
        checkOutput("sw_ram_addr", {57'd0, cap_ram_addr}, 64'd4);
        checkOutput("sw_wdata_hi", {32'd0, cap_wdata[63:32]}, 64'hAABB_CCDD);
        checkOutput("sw_mem", ram_mem[4], 64'hAABB_CCDD_0000_0000);
        runAccess(1'b1, 1'b0, 32'h0002_0024, SZ_W, 1'b1, 64'd0);
        checkOutput("lw_rdata", cap_rdata, 64'hFFFF_FFFF_AABB_CCDD);
        runAccess(1'b1, 1'b0, 32'h0002_0006, SZ_H, 1'b1, 64'd0);
        checkOutput("lh_rdata", cap_rdata, 64'h0123);

        // ROM word loads with one wait state.
        runAccess(1'b1, 1'b0, 32'h0000_0004, SZ_W, 1'b0, 64'd0);
        checkOutput("rom_first_en", 64'(cap_first_en), 64'd1);
        checkOutput("rom_en_cycles", 64'(cap_en_cycles), 64'd2);
        checkOutput("rom_addr", {57'd0, cap_rom_addr}, 64'd0);
        checkOutput("rom_ready_cyc", 64'(cap_ready_cyc), 64'd3);
        checkOutput("rom_rdata", cap_rdata, 64'h0000_0000_DEAD_BEEF);
        runAccess(1'b1, 1'b0, 32'h0000_0004, SZ_W, 1'b1, 64'd0);
        checkOutput("rom_srdata", cap_rdata, 64'hFFFF_FFFF_DEAD_BEEF);

        // Faults: ready+error in cycle 1, no device enable.
        runAccess(1'b1, 1'b0, 32'h0002_0001, SZ_H, 1'b0, 64'd0);
        checkOutput("f_mis_resp", {cap_ready_cyc[7:0], 7'd0, cap_err, 31'd0, cap_en_cycles[0]}, {8'd1, 7'd0, 1'b1, 32'd0});
        runAccess(1'b0, 1'b1, 32'h0000_0010, SZ_D, 1'b0, 64'h55);
        checkOutput("f_romwr_resp", {cap_ready_cyc[7:0], 7'd0, cap_err, 31'd0, cap_en_cycles[0]}, {8'd1, 7'd0, 1'b1, 32'd0});
        checkOutput("f_romwr_rdata", cap_rdata, 64'd0);
        runAccess(1'b1, 1'b0, 32'h0010_0000, SZ_D, 1'b0, 64'd0);
        checkOutput("f_unmap_resp", {cap_ready_cyc[7:0], 7'd0, cap_err, 31'd0, cap_en_cycles[0]}, {8'd1, 7'd0, 1'b1, 32'd0});
        runAccess(1'b1, 1'b1, 32'h0002_0000, SZ_D, 1'b0, 64'd0);
        checkOutput("f_rdwr_resp", {cap_ready_cyc[7:0], 7'd0, cap_err, 31'd0, cap_en_cycles[0]}, {8'd1, 7'd0, 1'b1, 32'd0});
        checkOutput("f_rdwr_en", 64'(cap_en_cycles), 64'd0);

        // Back-to-back RAM reads: request held, address changed in the ready cycle.
        applyStimulus(1'b1, 1'b0, 32'h0002_0000, SZ_D, 1'b0, 64'd0);
        for (int c = 1; c <= 5; c++) begin
            stepCycle();
            b2b_ready[c] = req_ready;
            b2b_rdata[c] = req_rdata;
            if (c == 2) req_addr = 32'h0002_0010;
            if (c == 4) applyStimulus(1'b0, 1'b0, 32'd0, SZ_B, 1'b0, 64'd0);
        end
        checkOutput("b2b_ready", {59'd0, b2b_ready[1], b2b_ready[2], b2b_ready[3], b2b_ready[4], b2b_ready[5]}, 64'b01001);
        checkOutput("b2b_rdata1", b2b_rdata[2], 64'h0123_4567_80AB_CDEF);
        checkOutput("b2b_rdata2", b2b_rdata[5], 64'hCAFE_F00D_0BAD_BEEF);
        stepCycle();

        // Reset during the second ACCESS cycle of a ROM read.
        applyStimulus(1'b1, 1'b0, 32'h0000_0008, SZ_D, 1'b0, 64'd0);
        stepCycle();
        applyStimulus(1'b0, 1'b0, 32'd0, SZ_B, 1'b0, 64'd0);
        stepCycle();
        checkOutput("mid_rom_en", {63'd0, rom_en}, 64'd1);
        reset = 1'b1;
        #1;
        checkOutput("mid_rst_ports", {rom_en, ram_en, req_ready, req_error, rom_addr}, 64'd0);
        checkOutput("mid_rst_rdata", req_rdata, 64'd0);
        stepCycle();
        reset = 1'b0;
        stepCycle();
        checkOutput("post_rst_ready_a", {63'd0, req_ready}, 64'd0);
        stepCycle();
        checkOutput("post_rst_ready_b", {63'd0, req_ready}, 64'd0);
        runAccess(1'b1, 1'b0, 32'h0000_0008, SZ_D, 1'b0, 64'd0);
        checkOutput("post_rst_cyc", 64'(cap_ready_cyc), 64'd3);
        checkOutput("post_rst_rdata", cap_rdata, 64'h0F1E_2D3C_4B5A_6978);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
